// File: rtl/arbiter_in_node_v2.sv
// arbiter_in_node_v2: input-side wormhole arbiter for the ring node.
// Steers req/rep packets to the ic/dc/mem download registers.
module arbiter_in_node_v2 #(
  parameter int FLIT_W        = 16,
  parameter int CMD_MSB       = 9,
  parameter int CMD_LSB       = 5,
  parameter logic [CMD_MSB-CMD_LSB:0] INSTREP_CMD = 5'b10100,
  parameter int MEM_BIT       = 13,
  parameter int STARVE_MAX    = 4,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req_rdy,
  input  logic              in_rep_rdy,
  input  logic [1:0]        req_ctrl_in,
  input  logic [1:0]        rep_ctrl_in,
  input  logic [FLIT_W-1:0] req_flit_in,
  input  logic [FLIT_W-1:0] rep_flit_in,
  input  logic [1:0]        ic_download_state_in,
  input  logic [1:0]        dc_download_state_in,
  input  logic [1:0]        mem_download_state_in,
  output logic              ack_req,
  output logic              ack_rep,
  output logic              v_ic,
  output logic              v_dc,
  output logic              v_mem,
  output logic [FLIT_W-1:0] flit_ic,
  output logic [FLIT_W-1:0] flit_dc,
  output logic [FLIT_W-1:0] flit_mem,
  output logic [1:0]        ctrl_ic,
  output logic [1:0]        ctrl_dc,
  output logic [1:0]        ctrl_mem,
  output logic              req_boost,
  output logic              err_pkt
);

  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_HEAD = 2'b01;
  localparam logic [1:0] C_BODY = 2'b10;
  localparam logic [1:0] C_TAIL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IC   = 2'd1,
    S_DC   = 2'd2,
    S_MEM  = 2'd3
  } state_e;

  // index 0 is the rep channel, index 1 the req channel
  state_e            state_q [2];
  state_e            state_d [2];
  logic [CNT_W-1:0]  cnt_q   [2];
  logic [CNT_W-1:0]  cnt_d   [2];
  logic [STV_W-1:0]  starve_q;
  logic [STV_W-1:0]  starve_d;
  logic              err_q;
  logic              err_d;

  logic              rdy  [2];
  logic [1:0]        ctrl [2];
  logic [FLIT_W-1:0] flit [2];
  state_e            tgt  [2];
  state_e            dst  [2];
  logic              try_hd [2];
  logic              win  [2];
  logic              fwd  [2];
  logic              ack  [2];
  logic [3:0]        dst_idle;
  logic              conflict;
  logic              boost;
  logic              err_set;

  assign rdy[0]  = in_rep_rdy;
  assign rdy[1]  = in_req_rdy;
  assign ctrl[0] = rep_ctrl_in;
  assign ctrl[1] = req_ctrl_in;
  assign flit[0] = rep_flit_in;
  assign flit[1] = req_flit_in;

  assign dst_idle = {
    mem_download_state_in == 2'b00,
    dc_download_state_in == 2'b00,
    ic_download_state_in == 2'b00,
    1'b0
  };

  // head-flit destination decode
  always_comb begin
    tgt[0] = rep_flit_in[MEM_BIT] ? S_MEM : S_DC;
    if (rep_flit_in[CMD_MSB:CMD_LSB] == INSTREP_CMD)
      tgt[0] = S_IC;
    tgt[1] = req_flit_in[MEM_BIT] ? S_MEM : S_DC;
  end

  // head arbitration and starvation guard
  always_comb begin
    boost = (starve_q == STV_W'(STARVE_MAX));
    try_hd[0] = (state_q[0] == S_IDLE) && rdy[0] &&
                (ctrl[0] == C_HEAD) && dst_idle[tgt[0]] &&
                (state_q[1] != tgt[0]);
    try_hd[1] = (state_q[1] == S_IDLE) && rdy[1] &&
                (ctrl[1] == C_HEAD) && dst_idle[tgt[1]] &&
                (state_q[0] != tgt[1]);
    conflict = try_hd[0] && try_hd[1] && (tgt[0] == tgt[1]);
    win[0] = try_hd[0] && !(conflict && boost);
    win[1] = try_hd[1] && !(conflict && !boost);
    starve_d = starve_q;
    if (win[1])
      starve_d = '0;
    else if (conflict && !boost)
      starve_d = starve_q + 1'b1;
  end

  // per-channel lock, forwarding, drain and error detection
  always_comb begin
    err_set = 1'b0;
    for (int c = 0; c < 2; c++) begin
      fwd[c]     = 1'b0;
      ack[c]     = 1'b0;
      dst[c]     = state_q[c];
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (state_q[c] == S_IDLE) begin
        if (win[c]) begin
          fwd[c]     = 1'b1;
          ack[c]     = 1'b1;
          dst[c]     = tgt[c];
          state_d[c] = tgt[c];
          cnt_d[c]   = CNT_W'(1);
        end else if (rdy[c] && ctrl[c] != C_HEAD) begin
          ack[c]  = 1'b1;
          err_set = 1'b1;
        end
      end else if (rdy[c]) begin
        fwd[c]   = 1'b1;
        ack[c]   = 1'b1;
        cnt_d[c] = cnt_q[c] + 1'b1;
        if (ctrl[c] == C_TAIL) begin
          state_d[c] = S_IDLE;
        end else begin
          if (ctrl[c] != C_BODY)
            err_set = 1'b1;
          if (cnt_d[c] == CNT_W'(MAX_PKT_FLITS)) begin
            err_set    = 1'b1;
            state_d[c] = S_IDLE;
          end
        end
      end
    end
    if (rst) begin
      err_set = 1'b0;
      for (int c = 0; c < 2; c++) begin
        fwd[c] = 1'b0;
        ack[c] = 1'b0;
      end
    end
    err_d = err_q | err_set;
  end

  // destination output steering
  always_comb begin
    ack_rep  = ack[0];
    ack_req  = ack[1];
    v_ic     = fwd[0] && (dst[0] == S_IC);
    flit_ic  = v_ic ? flit[0] : '0;
    ctrl_ic  = v_ic ? ctrl[0] : C_NONE;
    v_dc     = 1'b0;
    flit_dc  = '0;
    ctrl_dc  = C_NONE;
    v_mem    = 1'b0;
    flit_mem = '0;
    ctrl_mem = C_NONE;
    for (int c = 0; c < 2; c++) begin
      if (fwd[c] && dst[c] == S_DC) begin
        v_dc    = 1'b1;
        flit_dc = flit[c];
        ctrl_dc = ctrl[c];
      end
      if (fwd[c] && dst[c] == S_MEM) begin
        v_mem    = 1'b1;
        flit_mem = flit[c];
        ctrl_mem = ctrl[c];
      end
    end
  end

  assign req_boost = boost;
  assign err_pkt   = err_q;

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
      end
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_arbiter_in_node_v2.sv
// tb_arbiter_in_node_v2: directed plan steps plus random traffic,
// checked every cycle against a packet-level reference model.
module tb_arbiter_in_node_v2;

  localparam int FW   = 16;
  localparam int SMAX = 4;
  localparam int MAXF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_req_rdy = 1'b0;
  logic          in_rep_rdy = 1'b0;
  logic [1:0]    req_ctrl_in = '0;
  logic [1:0]    rep_ctrl_in = '0;
  logic [FW-1:0] req_flit_in = '0;
  logic [FW-1:0] rep_flit_in = '0;
  logic [1:0]    ic_st = '0;
  logic [1:0]    dc_st = '0;
  logic [1:0]    mem_st = '0;
  logic          ack_req, ack_rep;
  logic          v_ic, v_dc, v_mem;
  logic [FW-1:0] flit_ic, flit_dc, flit_mem;
  logic [1:0]    ctrl_ic, ctrl_dc, ctrl_mem;
  logic          req_boost, err_pkt;

  arbiter_in_node_v2 #(
    .FLIT_W(FW),
    .STARVE_MAX(SMAX),
    .MAX_PKT_FLITS(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_req_rdy(in_req_rdy),
    .in_rep_rdy(in_rep_rdy),
    .req_ctrl_in(req_ctrl_in),
    .rep_ctrl_in(rep_ctrl_in),
    .req_flit_in(req_flit_in),
    .rep_flit_in(rep_flit_in),
    .ic_download_state_in(ic_st),
    .dc_download_state_in(dc_st),
    .mem_download_state_in(mem_st),
    .ack_req(ack_req),
    .ack_rep(ack_rep),
    .v_ic(v_ic),
    .v_dc(v_dc),
    .v_mem(v_mem),
    .flit_ic(flit_ic),
    .flit_dc(flit_dc),
    .flit_mem(flit_mem),
    .ctrl_ic(ctrl_ic),
    .ctrl_dc(ctrl_dc),
    .ctrl_mem(ctrl_mem),
    .req_boost(req_boost),
    .err_pkt(err_pkt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: locked destination per channel (0 none, 1 ic, 2 dc, 3 mem)
  int m_lock [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  int m_starve = 0;
  bit m_err = 1'b0;
  int x_lock [2];
  int x_cnt  [2];
  int x_starve;
  bit x_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rep(input logic r, input logic [1:0] c,
                     input logic [FW-1:0] f);
    in_rep_rdy  = r;
    rep_ctrl_in = c;
    rep_flit_in = f;
  endtask

  task automatic req(input logic r, input logic [1:0] c,
                     input logic [FW-1:0] f);
    in_req_rdy  = r;
    req_ctrl_in = c;
    req_flit_in = f;
  endtask

  // mid-cycle: predict this cycle's outputs and next model state
  task automatic at_mid();
    bit            rdy [2];
    logic [1:0]    ct  [2];
    logic [FW-1:0] fl  [2];
    int            tgt [2];
    bit            cand [2];
    bit            win [2];
    bit            lose;
    int            ds  [4];
    bit            ev  [4];
    logic [FW-1:0] ef  [4];
    logic [1:0]    ec  [4];
    bit            ea  [2];
    int            d;
    @(negedge clk);
    rdy[0] = in_rep_rdy;
    rdy[1] = in_req_rdy;
    ct[0]  = rep_ctrl_in;
    ct[1]  = req_ctrl_in;
    fl[0]  = rep_flit_in;
    fl[1]  = req_flit_in;
    ds[0] = 0;
    ds[1] = int'(ic_st);
    ds[2] = int'(dc_st);
    ds[3] = int'(mem_st);
    for (int k = 0; k < 4; k++) begin
      ev[k] = 1'b0;
      ef[k] = '0;
      ec[k] = '0;
    end
    ea[0] = 1'b0;
    ea[1] = 1'b0;
    x_lock   = m_lock;
    x_cnt    = m_cnt;
    x_starve = m_starve;
    x_err    = m_err;
    if (rst) begin
      x_lock   = '{0, 0};
      x_cnt    = '{0, 0};
      x_starve = 0;
      x_err    = 1'b0;
    end else begin
      tgt[0] = (fl[0][9:5] == 5'b10100) ? 1 : (fl[0][13] ? 3 : 2);
      tgt[1] = fl[1][13] ? 3 : 2;
      for (int c = 0; c < 2; c++)
        cand[c] = m_lock[c] == 0 && rdy[c] && ct[c] == 2'b01 &&
                  ds[tgt[c]] == 0 && m_lock[1-c] != tgt[c];
      win  = cand;
      lose = 1'b0;
      if (cand[0] && cand[1] && tgt[0] == tgt[1]) begin
        if (m_starve == SMAX) win[0] = 1'b0;
        else begin
          win[1] = 1'b0;
          lose   = 1'b1;
        end
      end
      if (win[1]) x_starve = 0;
      else if (lose && m_starve < SMAX) x_starve = m_starve + 1;
      for (int c = 0; c < 2; c++) begin
        if (m_lock[c] == 0) begin
          if (win[c]) begin
            ea[c] = 1'b1;
            ev[tgt[c]] = 1'b1;
            ef[tgt[c]] = fl[c];
            ec[tgt[c]] = ct[c];
            x_lock[c] = tgt[c];
            x_cnt[c]  = 1;
          end else if (rdy[c] && ct[c] != 2'b01) begin
            ea[c] = 1'b1;
            x_err = 1'b1;
          end
        end else if (rdy[c]) begin
          d = m_lock[c];
          ea[c] = 1'b1;
          ev[d] = 1'b1;
          ef[d] = fl[c];
          ec[d] = ct[c];
          x_cnt[c] = m_cnt[c] + 1;
          if (ct[c] == 2'b11) x_lock[c] = 0;
          else begin
            if (ct[c] != 2'b10) x_err = 1'b1;
            if (x_cnt[c] == MAXF) begin
              x_err = 1'b1;
              x_lock[c] = 0;
            end
          end
        end
      end
    end
    chk("ack_rep", 32'(ack_rep), 32'(ea[0]));
    chk("ack_req", 32'(ack_req), 32'(ea[1]));
    chk("v_ic", 32'(v_ic), 32'(ev[1]));
    chk("v_dc", 32'(v_dc), 32'(ev[2]));
    chk("v_mem", 32'(v_mem), 32'(ev[3]));
    chk("flit_ic", 32'(flit_ic), 32'(ef[1]));
    chk("flit_dc", 32'(flit_dc), 32'(ef[2]));
    chk("flit_mem", 32'(flit_mem), 32'(ef[3]));
    chk("ctrl_ic", 32'(ctrl_ic), 32'(ec[1]));
    chk("ctrl_dc", 32'(ctrl_dc), 32'(ec[2]));
    chk("ctrl_mem", 32'(ctrl_mem), 32'(ec[3]));
    chk("req_boost", 32'(req_boost), 32'(m_starve == SMAX));
    chk("err_pkt", 32'(err_pkt), 32'(m_err));
  endtask

  task automatic adv();
    @(posedge clk);
    m_lock   = x_lock;
    m_cnt    = x_cnt;
    m_starve = x_starve;
    m_err    = x_err;
    #1;
  endtask

  task automatic cyc();
    at_mid();
    adv();
  endtask

  initial begin
    // flops are unknown until the first reset edge
    @(posedge clk);
    #1;
    at_mid();
    chk("rst_v_mem", 32'(v_mem), 0);
    chk("rst_boost", 32'(req_boost), 0);
    chk("rst_err", 32'(err_pkt), 0);
    adv();
    rst = 1'b0;

    // rep packet to ic
    rep(1, 2'b01, 16'h0280);
    at_mid();
    chk("ic_head_v", 32'(v_ic), 1);
    chk("ic_head_ctrl", 32'(ctrl_ic), 1);
    adv();
    rep(1, 2'b10, 16'h1111);
    at_mid();
    chk("ic_body_ctrl", 32'(ctrl_ic), 2);
    adv();
    rep(1, 2'b11, 16'h2222);
    at_mid();
    chk("ic_tail_ctrl", 32'(ctrl_ic), 3);
    chk("ic_tail_ack", 32'(ack_rep), 1);
    adv();
    rep(0, 2'b00, 16'h0000);
    at_mid();
    chk("ic_done_v", 32'(v_ic), 0);
    adv();

    // concurrent req->mem and rep->dc
    req(1, 2'b01, 16'h2000);
    rep(1, 2'b01, 16'h0001);
    at_mid();
    chk("cc_flit_mem", 32'(flit_mem), 32'h2000);
    chk("cc_flit_dc", 32'(flit_dc), 32'h0001);
    chk("cc_ack_req", 32'(ack_req), 1);
    chk("cc_ack_rep", 32'(ack_rep), 1);
    adv();
    req(1, 2'b11, 16'h2001);
    rep(1, 2'b11, 16'h0002);
    cyc();
    req(0, 2'b00, 16'h0000);
    rep(0, 2'b00, 16'h0000);
    cyc();

    // same-destination conflicts until req gets priority
    for (int k = 0; k < 4; k++) begin
      req(1, 2'b01, 16'h0004);
      rep(1, 2'b01, 16'h0003);
      at_mid();
      chk("stv_rep_wins", 32'(flit_dc), 32'h0003);
      chk("stv_req_held", 32'(ack_req), 0);
      adv();
      rep(1, 2'b11, 16'h0005);
      cyc();
    end
    rep(1, 2'b01, 16'h0003);
    at_mid();
    chk("stv_boost", 32'(req_boost), 1);
    chk("stv_req_wins", 32'(flit_dc), 32'h0004);
    chk("stv_rep_held", 32'(ack_rep), 0);
    adv();
    req(1, 2'b11, 16'h0006);
    at_mid();
    chk("stv_boost_clr", 32'(req_boost), 0);
    adv();
    req(0, 2'b00, 16'h0000);
    rep(0, 2'b00, 16'h0000);
    cyc();

    // busy destination holds the head
    dc_st = 2'b01;
    rep(1, 2'b01, 16'h0007);
    at_mid();
    chk("busy_ack", 32'(ack_rep), 0);
    chk("busy_v", 32'(v_dc), 0);
    adv();
    cyc();
    dc_st = 2'b00;
    at_mid();
    chk("busy_free_ack", 32'(ack_rep), 1);
    chk("busy_free_v", 32'(v_dc), 1);
    adv();
    rep(1, 2'b11, 16'h0008);
    cyc();
    rep(0, 2'b00, 16'h0000);
    cyc();

    // packet length limit
    req(1, 2'b01, 16'h2000);
    cyc();
    req(1, 2'b10, 16'h2100);
    cyc();
    req(1, 2'b10, 16'h2200);
    cyc();
    req(1, 2'b10, 16'h2300);
    at_mid();
    chk("len_fwd", 32'(flit_mem), 32'h2300);
    chk("len_err_before", 32'(err_pkt), 0);
    adv();
    req(1, 2'b10, 16'h2400);
    at_mid();
    chk("len_err", 32'(err_pkt), 1);
    chk("len_drop_ack", 32'(ack_req), 1);
    chk("len_drop_v", 32'(v_mem), 0);
    adv();
    req(0, 2'b00, 16'h0000);
    cyc();

    // reset in the middle of a mem packet
    rep(1, 2'b01, 16'h2000);
    cyc();
    rep(1, 2'b10, 16'h2010);
    cyc();
    rst = 1'b1;
    rep(1, 2'b10, 16'h2020);
    at_mid();
    chk("rmid_v", 32'(v_mem), 0);
    chk("rmid_ack", 32'(ack_rep), 0);
    adv();
    rst = 1'b0;
    rep(1, 2'b11, 16'h2030);
    at_mid();
    chk("rmid_drain_ack", 32'(ack_rep), 1);
    chk("rmid_drain_v", 32'(v_mem), 0);
    chk("rmid_err_clr", 32'(err_pkt), 0);
    adv();
    rep(1, 2'b01, 16'h2040);
    at_mid();
    chk("rmid_new_head", 32'(v_mem), 1);
    adv();
    rep(1, 2'b11, 16'h2050);
    cyc();
    rep(0, 2'b00, 16'h0000);
    cyc();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_rep_rdy  = ($urandom_range(0, 3) != 0);
      rep_ctrl_in = 2'($urandom_range(0, 3));
      rep_flit_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rep_flit_in[9:5] = 5'b10100;
      in_req_rdy  = ($urandom_range(0, 3) != 0);
      req_ctrl_in = 2'($urandom_range(0, 3));
      req_flit_in = 16'($urandom);
      ic_st  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      dc_st  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mem_st = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rst    = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
